// File: rtl/led_rm_checker_if.sv
// Boundary bundle between the reconfigurable LED test module and its static-region checker.
// The master side drives the RM-facing inputs (decouple, sample strobe, pattern).
// The slave side is the checker, which drives the pin and status outputs.
interface led_rm_checker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);

  logic             decouple;
  logic             rm_valid;
  logic [WIDTH-1:0] rm_led;
  logic [WIDTH-1:0] led_out;
  logic [1:0]       rm_id;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output decouple,
    output rm_valid,
    output rm_led,
    input  led_out,
    input  rm_id,
    input  locked,
    input  err,
    input  match_cnt,
    input  err_cnt
  );

  modport slave (
    input  decouple,
    input  rm_valid,
    input  rm_led,
    output led_out,
    output rm_id,
    output locked,
    output err,
    output match_cnt,
    output err_cnt
  );

endinterface

// File: rtl/led_rm_checker.sv
// Static-region checker for the partial LED test RM.
// Isolates the RM output while the partition is decoupled and waits a settle window after
// release. It then identifies the loaded variant (counter or left-rotating shifter) from
// consecutive samples and tracks pattern integrity with lock/err status and counters.
// Optional feature macro: RM_ERR_COUNT_EN implements the saturating mismatch counter.
// When the macro is undefined, err_cnt reads as zero.
module led_rm_checker #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_MATCHES  = 4,
  parameter int unsigned CNT_W         = 16
) (
  input logic             clk,
  input logic             rst,
  led_rm_checker_if.slave bus
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ConsecW = $clog2(LOCK_MATCHES + 1);

  typedef enum logic [2:0] {
    StDecoupled,
    StSettle,
    StAcquire,
    StClassify,
    StTrack
  } state_e;

  localparam logic [1:0] IdNone    = 2'd0;
  localparam logic [1:0] IdCounter = 2'd1;
  localparam logic [1:0] IdShifter = 2'd2;
  localparam logic [1:0] IdUnknown = 2'd3;

  state_e             state_q;
  logic [SettleW-1:0] settle_q;
  logic [ConsecW-1:0] consec_q;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   led_q;
  logic [1:0]         rm_id_q;
  logic               locked_q;
  logic               err_q;
  logic [CNT_W-1:0]   match_cnt_q;

  // Pattern predictions derived from the last accepted sample
  logic [WIDTH-1:0]   inc_val;
  logic [WIDTH-1:0]   rot_val;
  logic [WIDTH-1:0]   trk_exp;
  logic               is_inc;
  logic               is_rot;
  logic               trk_hit;
  logic               settle_done;
  logic [CNT_W-1:0]   match_cnt_sat;
  logic [ConsecW-1:0] consec_inc;

`ifdef RM_ERR_COUNT_EN
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   err_cnt_sat;
`endif

  // Next-pattern predictions, saturating increments and settle terminal count
  always_comb begin
    inc_val       = prev_q + WIDTH'(1);
    rot_val       = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    is_inc        = (bus.rm_led == inc_val);
    is_rot        = (bus.rm_led == rot_val);
    // TRACK is only entered with a counter or shifter identity
    trk_exp       = (rm_id_q == IdShifter) ? rot_val : inc_val;
    trk_hit       = (bus.rm_led == trk_exp);
    settle_done   = (settle_q == SettleW'(SETTLE_CYCLES - 1));
    match_cnt_sat = (&match_cnt_q) ? match_cnt_q : match_cnt_q + CNT_W'(1);
    consec_inc    = (consec_q == ConsecW'(LOCK_MATCHES)) ? consec_q : consec_q + ConsecW'(1);
`ifdef RM_ERR_COUNT_EN
    err_cnt_sat   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
`endif
  end

  // Checker FSM with all status outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDecoupled;
      settle_q    <= '0;
      consec_q    <= '0;
      prev_q      <= '0;
      led_q       <= '0;
      rm_id_q     <= IdNone;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      match_cnt_q <= '0;
`ifdef RM_ERR_COUNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      if (bus.decouple) begin
        // Partition under reconfiguration: drop identity, keep pins steady
        state_q  <= StDecoupled;
        rm_id_q  <= IdNone;
        locked_q <= 1'b0;
        settle_q <= '0;
      end else begin
        case (state_q)
          StDecoupled: begin
            // New session starts on release
            state_q     <= StSettle;
            settle_q    <= '0;
            consec_q    <= '0;
            match_cnt_q <= '0;
`ifdef RM_ERR_COUNT_EN
            err_cnt_q   <= '0;
`endif
          end
          StSettle: begin
            if (settle_done) begin
              state_q <= StAcquire;
            end else begin
              settle_q <= settle_q + SettleW'(1);
            end
          end
          StAcquire: begin
            if (bus.rm_valid) begin
              prev_q  <= bus.rm_led;
              led_q   <= bus.rm_led;
              state_q <= StClassify;
            end
          end
          StClassify: begin
            if (bus.rm_valid) begin
              led_q  <= bus.rm_led;
              prev_q <= bus.rm_led;
              if (is_inc && is_rot) begin
                // Both variants predict this sample; wait for a distinguishing one
                state_q <= StClassify;
              end else if (is_inc || is_rot) begin
                rm_id_q     <= is_inc ? IdCounter : IdShifter;
                match_cnt_q <= match_cnt_sat;
                consec_q    <= ConsecW'(1);
                locked_q    <= (LOCK_MATCHES == 1);
                state_q     <= StTrack;
              end else begin
                rm_id_q <= IdUnknown;
                err_q   <= 1'b1;
`ifdef RM_ERR_COUNT_EN
                err_cnt_q <= err_cnt_sat;
`endif
              end
            end
          end
          StTrack: begin
            if (bus.rm_valid) begin
              led_q  <= bus.rm_led;
              // Always follow the RM so a single glitch resyncs on the next sample
              prev_q <= bus.rm_led;
              if (trk_hit) begin
                match_cnt_q <= match_cnt_sat;
                consec_q    <= consec_inc;
                if (consec_inc == ConsecW'(LOCK_MATCHES)) begin
                  locked_q <= 1'b1;
                end
              end else begin
                err_q    <= 1'b1;
                consec_q <= '0;
                locked_q <= 1'b0;
`ifdef RM_ERR_COUNT_EN
                err_cnt_q <= err_cnt_sat;
`endif
              end
            end
          end
          default: begin
            state_q <= StDecoupled;
          end
        endcase
      end
    end
  end

  assign bus.led_out   = led_q;
  assign bus.rm_id     = rm_id_q;
  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.match_cnt = match_cnt_q;
`ifdef RM_ERR_COUNT_EN
  assign bus.err_cnt   = err_cnt_q;
`else
  assign bus.err_cnt   = '0;
`endif

endmodule

// File: tb/tb_led_rm_checker.sv
// Self-checking bench for led_rm_checker: directed scenarios followed by a random stream.
// Every cycle is scored against a behavioural model of the checker.
module tb_led_rm_checker;

  localparam int SETTLE = 16;
  localparam int LOCK   = 4;
  localparam int MAXC   = 31;  // CNT_W = 5 so saturation is reachable
`ifdef RM_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int M_DEC = 0;
  localparam int M_SET = 1;
  localparam int M_ACQ = 2;
  localparam int M_CLS = 3;
  localparam int M_TRK = 4;

  logic clk;
  logic rst;

  led_rm_checker_if #(.WIDTH(8), .CNT_W(5)) bus ();

  led_rm_checker #(
    .WIDTH        (8),
    .SETTLE_CYCLES(SETTLE),
    .LOCK_MATCHES (LOCK),
    .CNT_W        (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_mode, m_wait, m_prev, m_led, m_id, m_lock, m_err, m_mc, m_ec, m_run;

  function automatic int rotl8(input int p);
    return ((p << 1) | (p >> 7)) & 255;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= MAXC) ? MAXC : c + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit d, input bit v, input int l);
    bit inc;
    bit rot;
    int expv;
    m_err = 0;
    if (r) begin
      m_mode = M_DEC; m_wait = 0; m_prev = 0; m_led = 0; m_id = 0;
      m_lock = 0; m_mc = 0; m_ec = 0; m_run = 0;
    end else if (d) begin
      m_mode = M_DEC; m_id = 0; m_lock = 0;
    end else if (m_mode == M_DEC) begin
      m_mode = M_SET; m_wait = 0; m_mc = 0; m_ec = 0; m_run = 0;
    end else if (m_mode == M_SET) begin
      m_wait = m_wait + 1;
      if (m_wait == SETTLE) m_mode = M_ACQ;
    end else if (v) begin
      m_led = l;
      if (m_mode == M_CLS) begin
        inc = (l == ((m_prev + 1) & 255));
        rot = (l == rotl8(m_prev));
        if (inc != rot) begin
          m_id   = inc ? 1 : 2;
          m_mc   = sat_inc(m_mc);
          m_run  = 1;
          m_lock = (m_run >= LOCK) ? 1 : 0;
          m_mode = M_TRK;
        end else if (!inc) begin
          m_id  = 3;
          m_err = 1;
          m_ec  = sat_inc(m_ec);
        end
      end else if (m_mode == M_TRK) begin
        expv = (m_id == 1) ? ((m_prev + 1) & 255) : rotl8(m_prev);
        if (l == expv) begin
          m_mc  = sat_inc(m_mc);
          m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
          if (m_run == LOCK) m_lock = 1;
        end else begin
          m_err = 1; m_ec = sat_inc(m_ec); m_run = 0; m_lock = 0;
        end
      end else begin
        m_mode = M_CLS;
      end
      m_prev = l;
    end
  endtask

  // One clock: drive, advance model on the edge, compare every output 1 time unit later
  task automatic cyc(input bit r, input bit d, input bit v, input int l);
    rst          = r;
    bus.decouple = d;
    bus.rm_valid = v;
    bus.rm_led   = l[7:0];
    @(posedge clk);
    model_edge(r, d, v, l);
    #1;
    chk("led_out", 32'(bus.led_out), 32'(m_led));
    chk("rm_id", 32'(bus.rm_id), 32'(m_id));
    chk("locked", 32'(bus.locked), 32'(m_lock));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("match_cnt", 32'(bus.match_cnt), 32'(m_mc));
    chk("err_cnt", 32'(bus.err_cnt), ERR_EN ? 32'(m_ec) : 32'd0);
  endtask

  // Release decouple and run the full settle window with ignored garbage samples
  task automatic release_settle();
    cyc(0, 0, 1, 8'h3C);
    chk("rel_match_clr", 32'(bus.match_cnt), 32'd0);
    chk("rel_err_clr", 32'(bus.err_cnt), 32'd0);
    for (int i = 0; i < SETTLE; i++) cyc(0, 0, 1, int'($urandom_range(0, 255)));
    chk("settle_no_err", 32'(bus.err), 32'd0);
  endtask

  int  p;
  int  g_last;
  int  l;
  bit  r;
  bit  d;
  bit  v;

  initial begin
    rst = 1'b1; bus.decouple = 1'b0; bus.rm_valid = 1'b0; bus.rm_led = '0;
    m_mode = M_DEC; m_wait = 0; m_prev = 0; m_led = 0; m_id = 0;
    m_lock = 0; m_err = 0; m_mc = 0; m_ec = 0; m_run = 0;

    // Reset
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'hAA);
    chk("rst_led", 32'(bus.led_out), 32'd0);
    chk("rst_id", 32'(bus.rm_id), 32'd0);
    chk("rst_lock", 32'(bus.locked), 32'd0);

    // Counter RM: samples during release + settle are ignored
    for (int i = 0; i <= SETTLE; i++) cyc(0, 0, 1, 8'hE0 + i);
    chk("settle_bound_led", 32'(bus.led_out), 32'd0);
    cyc(0, 0, 1, 8'h10);
    chk("acq_led", 32'(bus.led_out), 32'h10);
    chk("acq_id", 32'(bus.rm_id), 32'd0);
    cyc(0, 0, 1, 8'h11);
    chk("ctr_id", 32'(bus.rm_id), 32'd1);
    cyc(0, 0, 1, 8'h12);
    cyc(0, 0, 1, 8'h13);
    chk("ctr_not_locked", 32'(bus.locked), 32'd0);
    cyc(0, 0, 1, 8'h14);
    chk("ctr_locked", 32'(bus.locked), 32'd1);
    for (int i = 8'h15; i <= 8'h20; i++) cyc(0, 0, 1, i);

    // Mismatch in TRACK, then resync and relock
    cyc(0, 0, 1, 8'h55);
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_lock", 32'(bus.locked), 32'd0);
    chk("mis_errcnt", 32'(bus.err_cnt), ERR_EN ? 32'd1 : 32'd0);
    cyc(0, 0, 1, 8'h56);
    chk("resync_no_err", 32'(bus.err), 32'd0);
    cyc(0, 0, 0, 8'hFF);  // gap
    cyc(0, 0, 1, 8'h57);
    cyc(0, 0, 1, 8'h58);
    chk("relock_pending", 32'(bus.locked), 32'd0);
    cyc(0, 0, 1, 8'h59);
    chk("relock", 32'(bus.locked), 32'd1);
    chk("ctr_match_cnt", 32'(bus.match_cnt), 32'd20);

    // Decouple mid-TRACK with garbage
    cyc(0, 1, 1, 8'hA5);
    chk("dec_id", 32'(bus.rm_id), 32'd0);
    chk("dec_lock", 32'(bus.locked), 32'd0);
    cyc(0, 1, 1, 8'h5A);
    cyc(0, 1, 1, 8'hC3);
    chk("dec_led_hold", 32'(bus.led_out), 32'h59);
    release_settle();

    // Shifter RM with 0x80 -> 0x01 wrap
    cyc(0, 0, 1, 8'h40);
    cyc(0, 0, 1, 8'h80);
    chk("shf_id", 32'(bus.rm_id), 32'd2);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'h02);
    chk("shf_match_cnt", 32'(bus.match_cnt), 32'd3);

    // Ambiguous 0x01 -> 0x02, resolved by 0x04
    cyc(0, 1, 0, 0);
    release_settle();
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'h02);
    chk("amb_id", 32'(bus.rm_id), 32'd0);
    chk("amb_no_err", 32'(bus.err), 32'd0);
    cyc(0, 0, 1, 8'h04);
    chk("amb_resolved", 32'(bus.rm_id), 32'd2);

    // Unknown RM, then err_cnt saturation
    cyc(0, 1, 0, 0);
    release_settle();
    cyc(0, 0, 1, 8'h33);
    cyc(0, 0, 1, 8'h99);
    chk("unk_id", 32'(bus.rm_id), 32'd3);
    chk("unk_err", 32'(bus.err), 32'd1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, (i % 2 == 0) ? 8'h00 : 8'h55);
    chk("err_cnt_sat", 32'(bus.err_cnt), ERR_EN ? 32'd31 : 32'd0);

    // Counter wrap 0xFF -> 0x00 and match_cnt saturation
    cyc(0, 1, 0, 0);
    release_settle();
    for (int i = 0; i < 48; i++) cyc(0, 0, 1, (8'hF0 + i) & 255);
    chk("match_cnt_sat", 32'(bus.match_cnt), 32'd31);
    chk("wrap_locked", 32'(bus.locked), 32'd1);

    // Random stream with occasional decouple and reset
    g_last = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 999) < 2);
      d = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 70);
      p = int'($urandom_range(0, 99));
      if (p < 45) l = (g_last + 1) & 255;
      else if (p < 85) l = rotl8(g_last);
      else l = int'($urandom_range(0, 255));
      if (v) g_last = l;
      cyc(r, d, v, l);
    end

    // Reset overrides decouple
    cyc(1, 1, 1, 8'h77);
    chk("final_rst_led", 32'(bus.led_out), 32'd0);
    chk("final_rst_cnt", 32'(bus.match_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
